read_ptr_empty: RTL and testbench

// - Read-domain pointer/flag generator for the async FIFO; the reader-side counterpart of the write pointer.
// - Holds the binary and Gray read pointers and drives the RAM read address.
// - Computes a registered empty flag against the Gray write pointer already synchronized into clk_in (sync_wrptr).
// - Exports the Gray read pointer for synchronization back into the write domain.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/read_ptr_empty_if.sv | 42 ++++
 rtl/read_ptr_empty_gray2bin_conv.sv | 19 +
 rtl/read_ptr_empty.sv | 105 ++++++++++
 tb/tb_read_ptr_empty.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and pointer width.
// Used by both the reader-side empty block and the writer-side full block.
package fifo_pkg;

  localparam int ADDRBITS = 8;
  localparam int PTR_W    = ADDRBITS + 1;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_ptr_empty_if.sv
// Reader-side bundle of the async FIFO: read request, synced write
// pointer in; Gray/binary read pointer, flags and level out.
interface read_ptr_empty_if #(
  parameter int addrbits = 8
);
  localparam int PTR_W = addrbits + 1;

  logic                rd_en;
  logic [PTR_W-1:0]    sync_wrptr;
  logic [PTR_W-1:0]    rdptr;
  logic [addrbits-1:0] raddr;
  logic                empty;
  logic                rd_ack;
  logic                rd_underflow;
  logic                almost_empty;
  logic [PTR_W-1:0]    rd_level;

  modport master (
    output rd_en,
    output sync_wrptr,
    input  rdptr,
    input  raddr,
    input  empty,
    input  rd_ack,
    input  rd_underflow,
    input  almost_empty,
    input  rd_level
  );

  modport slave (
    input  rd_en,
    input  sync_wrptr,
    output rdptr,
    output raddr,
    output empty,
    output rd_ack,
    output rd_underflow,
    output almost_empty,
    output rd_level
  );

endinterface

// File: rtl/read_ptr_empty_gray2bin_conv.sv
// Combinational Gray-to-binary converter, width W.
// Ports: gray_i (W) in, bin_o (W) out.
module gray2bin_conv
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [31:0] wide;

  always_comb begin
    wide  = gray2bin(32'(gray_i));
    bin_o = wide[W-1:0];
  end

endmodule

// File: rtl/read_ptr_empty.sv
// Read-domain pointer/empty flag generator for the async FIFO.
// Ports: clk_in, rst (async, active-low), flush (sync clear), bus (slave):
//   rd_en, sync_wrptr in; rdptr, raddr, empty, rd_ack, rd_underflow,
//   almost_empty, rd_level out. Macro FIFO_ALMOST_EMPTY_EN enables
//   rd_level/almost_empty; otherwise both are tied 0.
module read_ptr_empty
  import fifo_pkg::*;
#(
  parameter int addrbits  = 8,
  parameter int AE_THRESH = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             flush,
  read_ptr_empty_if.slave  bus
);

  localparam int PW = addrbits + 1;

  logic [PW-1:0] rbin_q;
  logic [PW-1:0] rbin_d;
  logic [PW-1:0] rgray_q;
  logic [PW-1:0] rgray_d;
  logic [31:0]   gray_w;
  logic          empty_q;
  logic          ack_q;
  logic          udf_q;
  logic          rd_inc;

  always_comb begin
    rd_inc  = bus.rd_en & ~empty_q;
    rbin_d  = rbin_q + PW'(rd_inc);
    gray_w  = bin2gray(32'(rbin_d));
    rgray_d = gray_w[PW-1:0];
  end

  // Empty compares the next pointer with the incoming synced write
  // pointer, so a write landing with the last read keeps empty low.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (flush) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= (rgray_d == bus.sync_wrptr);
      ack_q   <= rd_inc;
      udf_q   <= bus.rd_en & empty_q;
    end
  end

  assign bus.rdptr        = rgray_q;
  assign bus.raddr        = rbin_q[addrbits-1:0];
  assign bus.empty        = empty_q;
  assign bus.rd_ack       = ack_q;
  assign bus.rd_underflow = udf_q;

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [PW-1:0] wbin;
  logic [PW-1:0] diff;
  logic [PW-1:0] lvl_q;
  logic          ae_q;

  gray2bin_conv #(
    .W (PW)
  ) u_g2b (
    .gray_i (bus.sync_wrptr),
    .bin_o  (wbin)
  );

  assign diff = wbin - rbin_d;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      lvl_q <= '0;
      ae_q  <= 1'b1;
    end else if (flush) begin
      lvl_q <= '0;
      ae_q  <= 1'b1;
    end else begin
      lvl_q <= diff;
      ae_q  <= (diff <= PW'(AE_THRESH));
    end
  end

  assign bus.rd_level     = lvl_q;
  assign bus.almost_empty = ae_q;
`else
  logic [31:0] unused_ae_thresh;
  assign unused_ae_thresh = 32'(AE_THRESH);

  assign bus.rd_level     = '0;
  assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_empty.sv
// Directed bench for read_ptr_empty (addrbits=3, AE_THRESH=2).
// Covers reset, drain, wrap, simultaneous write/read, flush, level.
module tb_read_ptr_empty;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  read_ptr_empty_if #(.addrbits(3)) bus_if ();

  read_ptr_empty #(
    .addrbits  (3),
    .AE_THRESH (2)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .flush  (flush),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] g(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.rd_en = 1'b1;
    bus_if.sync_wrptr = 4'b0000;
    step();
    step();
    ncmp++;
    if (bus_if.rdptr !== 4'b0000) begin
      $display("FAIL rst_rdptr got %b want 0000", bus_if.rdptr);
      nerr++;
    end
    ncmp++;
    if (bus_if.raddr !== 3'b000) begin
      $display("FAIL rst_raddr got %b want 000", bus_if.raddr);
      nerr++;
    end
    ncmp++;
    if (bus_if.empty !== 1'b1) begin
      $display("FAIL rst_empty got %b want 1", bus_if.empty);
      nerr++;
    end
    ncmp++;
    if (bus_if.rd_ack !== 1'b0) begin
      $display("FAIL rst_ack got %b want 0", bus_if.rd_ack);
      nerr++;
    end
`ifdef FIFO_ALMOST_EMPTY_EN
    ncmp++;
    if (bus_if.almost_empty !== 1'b1) begin
      $display("FAIL rst_ae got %b want 1", bus_if.almost_empty);
      nerr++;
    end
`endif
    rst = 1'b1;
    step();
    ncmp++;
    if (bus_if.rd_underflow !== 1'b1) begin
      $display("FAIL rst_udf got %b want 1", bus_if.rd_underflow);
      nerr++;
    end
    ncmp++;
    if (bus_if.rdptr !== 4'b0000) begin
      $display("FAIL rst_udf_ptr got %b want 0000", bus_if.rdptr);
      nerr++;
    end
    bus_if.rd_en = 1'b0;
    step();
  endtask

  task automatic test_fill_drain();
    logic [3:0] exp_ptr [3];
    exp_ptr[0] = 4'b0001;
    exp_ptr[1] = 4'b0011;
    exp_ptr[2] = 4'b0010;
    bus_if.sync_wrptr = 4'b0010;
    step();
    ncmp++;
    if (bus_if.empty !== 1'b0) begin
      $display("FAIL fill_empty got %b want 0", bus_if.empty);
      nerr++;
    end
    bus_if.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ncmp++;
      if (bus_if.rdptr !== exp_ptr[i]) begin
        $display("FAIL drain_ptr%0d got %b want %b",
                 i, bus_if.rdptr, exp_ptr[i]);
        nerr++;
      end
      ncmp++;
      if (bus_if.rd_ack !== 1'b1) begin
        $display("FAIL drain_ack%0d got %b want 1", i, bus_if.rd_ack);
        nerr++;
      end
      ncmp++;
      if (bus_if.empty !== (i == 2)) begin
        $display("FAIL drain_empty%0d got %b want %b",
                 i, bus_if.empty, (i == 2));
        nerr++;
      end
    end
    step();
    ncmp++;
    if (bus_if.rd_underflow !== 1'b1 || bus_if.rd_ack !== 1'b0) begin
      $display("FAIL drain_udf got udf=%b ack=%b want udf=1 ack=0",
               bus_if.rd_underflow, bus_if.rd_ack);
      nerr++;
    end
    ncmp++;
    if (bus_if.rdptr !== 4'b0010) begin
      $display("FAIL drain_hold got %b want 0010", bus_if.rdptr);
      nerr++;
    end
    bus_if.rd_en = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    int e = 3;
    int w;
    bit inc;
    bit exp_empty = 1'b1;
    bit wrap_seen = 1'b0;
    logic [3:0] prev;
    for (int i = 0; i < 40 && e < 16; i++) begin
      w = (e + 4 > 16) ? 16 : e + 4;
      bus_if.sync_wrptr = g(w % 16);
      bus_if.rd_en = 1'b1;
      inc = !exp_empty;
      prev = bus_if.rdptr;
      step();
      if (inc) e++;
      exp_empty = ((e % 16) == (w % 16));
      ncmp++;
      if (bus_if.rdptr !== g(e % 16) || bus_if.empty !== exp_empty) begin
        $display("FAIL wrap_step%0d got ptr=%b empty=%b want ptr=%b empty=%b",
                 i, bus_if.rdptr, bus_if.empty, g(e % 16), exp_empty);
        nerr++;
      end
      if (inc) begin
        ncmp++;
        if ($countones(prev ^ bus_if.rdptr) != 1) begin
          $display("FAIL wrap_onebit%0d got %b->%b want 1 bit change",
                   i, prev, bus_if.rdptr);
          nerr++;
        end
        if (prev == 4'b1000 && bus_if.rdptr == 4'b0000) wrap_seen = 1'b1;
      end
    end
    ncmp++;
    if (e != 16) begin
      $display("FAIL wrap_timeout got reads=%0d want 16", e);
      nerr++;
    end
    ncmp++;
    if (wrap_seen !== 1'b1 || bus_if.empty !== 1'b1) begin
      $display("FAIL wrap_end got wrap=%b empty=%b want 1 1",
               wrap_seen, bus_if.empty);
      nerr++;
    end
    bus_if.rd_en = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    bus_if.sync_wrptr = g(1);
    step();
    bus_if.rd_en = 1'b1;
    bus_if.sync_wrptr = g(2);
    step();
    ncmp++;
    if (bus_if.empty !== 1'b0 || bus_if.rd_ack !== 1'b1) begin
      $display("FAIL simul got empty=%b ack=%b want 0 1",
               bus_if.empty, bus_if.rd_ack);
      nerr++;
    end
    ncmp++;
    if (bus_if.rdptr !== 4'b0001) begin
      $display("FAIL simul_ptr got %b want 0001", bus_if.rdptr);
      nerr++;
    end
    bus_if.rd_en = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bus_if.sync_wrptr = g(6);
    step();
    flush = 1'b1;
    bus_if.rd_en = 1'b1;
    step();
    flush = 1'b0;
    bus_if.rd_en = 1'b0;
    ncmp++;
    if (bus_if.rdptr !== 4'b0000 || bus_if.raddr !== 3'b000) begin
      $display("FAIL flush_ptr got %b/%b want 0000/000",
               bus_if.rdptr, bus_if.raddr);
      nerr++;
    end
    ncmp++;
    if (bus_if.empty !== 1'b1 || bus_if.rd_ack !== 1'b0) begin
      $display("FAIL flush_flags got empty=%b ack=%b want 1 0",
               bus_if.empty, bus_if.rd_ack);
      nerr++;
    end
  endtask

  task automatic test_level();
    logic [3:0] exp_lvl [3];
    logic       exp_ae  [3];
    exp_lvl[0] = 4'd4;
    exp_lvl[1] = 4'd3;
    exp_lvl[2] = 4'd2;
    exp_ae[0] = 1'b0;
    exp_ae[1] = 1'b0;
    exp_ae[2] = 1'b1;
    bus_if.sync_wrptr = g(5);
    step();
`ifdef FIFO_ALMOST_EMPTY_EN
    ncmp++;
    if (bus_if.rd_level !== 4'd5 || bus_if.almost_empty !== 1'b0) begin
      $display("FAIL lvl_init got %0d ae=%b want 5 0",
               bus_if.rd_level, bus_if.almost_empty);
      nerr++;
    end
`endif
    bus_if.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
`ifdef FIFO_ALMOST_EMPTY_EN
      ncmp++;
      if (bus_if.rd_level !== exp_lvl[i] ||
          bus_if.almost_empty !== exp_ae[i]) begin
        $display("FAIL lvl%0d got %0d ae=%b want %0d ae=%b", i,
                 bus_if.rd_level, bus_if.almost_empty,
                 exp_lvl[i], exp_ae[i]);
        nerr++;
      end
`else
      ncmp++;
      if (bus_if.rd_level !== 4'd0 || bus_if.almost_empty !== 1'b0) begin
        $display("FAIL lvl_off%0d got %0d ae=%b want 0 0 (ref %0d)", i,
                 bus_if.rd_level, bus_if.almost_empty, exp_lvl[i]);
        nerr++;
      end
`endif
    end
    ncmp++;
    if (bus_if.rdptr !== 4'b0010) begin
      $display("FAIL lvl_ptr got %b want 0010", bus_if.rdptr);
      nerr++;
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    ncmp++;
    if (bus_if.rdptr !== 4'b0000 || bus_if.empty !== 1'b1 ||
        bus_if.rd_ack !== 1'b0) begin
      $display("FAIL midrst got ptr=%b empty=%b ack=%b want 0000 1 0",
               bus_if.rdptr, bus_if.empty, bus_if.rd_ack);
      nerr++;
    end
    step();
    ncmp++;
    if (bus_if.rd_ack !== 1'b0) begin
      $display("FAIL midrst_ack got %b want 0", bus_if.rd_ack);
      nerr++;
    end
    bus_if.rd_en = 1'b0;
    rst = 1'b1;
    step();
  endtask

  initial begin
    bus_if.rd_en = 1'b0;
    bus_if.sync_wrptr = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_level();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
